// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Purpose
//    Shares the single 16-bit external SRAM controller between two 32-bit
//    requesters. Port 0 is the pipeline MEM stage. Port 1 is a secondary
//    master such as a loader or a debug port.
//
//    The arbiter grants one port at a time and latches that port's address,
//    store data and direction. It then fires a one-cycle read or write enable
//    into the controller and holds the operands stable until the transaction
//    completes. It captures the 32-bit read word and returns a one-cycle
//    acknowledge to the winning port.
//
//    All SRAM sequencing (the 16-bit half-word accesses) stays inside the
//    controller. This block only handshakes with it through
//    mem_*_en / mem_ready.
//
//    Transaction timeline, with E0 being the grant edge:
//       E0 .. E1  ISSUE  enable high for exactly one cycle
//       E1 .. E6  BUSY   controller works, mem_ready low until after E5
//       E6 .. E7  DONE   ack[gidx] high, rdata[gidx] valid
//       E8        earliest next grant (one transaction per 8 cycles)
//
// Configuration
//    SRAM_ARB_FIXED_PRIO_EN
//       Defined:   fixed priority; port 0 always wins simultaneous requests,
//                  and no priority pointer is built.
//       Undefined: round-robin; after each completion the pointer prefers
//                  the port that was not just served.
//
// Ports
//    clk                   system clock, rising edge
//    rst                   asynchronous active-high reset (shared with the
//                          SRAM controller)
//    req0/req1             access request per port
//    we0/we1               1 = write, 0 = read
//    addr0/addr1   [31:0]  word address (controller decodes [17:0])
//    wdata0/wdata1 [31:0]  store data, ignored for reads
//    rdata0/rdata1 [31:0]  registered read result, valid while ackN is high;
//                          each port's word is held until that port's next
//                          completion
//    ack0/ack1             one-cycle completion pulse
//    stall0/stall1         reqN & ~ackN, combinational pipeline freeze
//    mem_w_en/mem_r_en     one-cycle enables to the SRAM controller
//    mem_addr/mem_wdata    latched operands, stable from ISSUE through DONE
//    mem_rdata     [31:0]  controller read data
//    mem_ready             controller idle; low while a transaction runs
// -----------------------------------------------------------------------------
module sram_arbiter (
   input  logic        clk,
   input  logic        rst,

   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   output logic [31:0] rdata0,
   output logic        ack0,
   output logic        stall0,

   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic [31:0] rdata1,
   output logic        ack1,
   output logic        stall1,

   output logic        mem_w_en,
   output logic        mem_r_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q,  addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q,    we_d;
   logic        gidx_q,  gidx_d;
   logic [31:0] rbuf_q,  rbuf_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;

   // Grant selection for the current IDLE cycle.
   logic grant_valid;
   logic grant_idx;

`ifndef SRAM_ARB_FIXED_PRIO_EN
   // Priority pointer: 0 prefers port 0, 1 prefers port 1.
   logic prio_q, prio_d;
`endif

   // -------------------------------------------------------------------------
   // Grant selection
   // -------------------------------------------------------------------------
   always_comb begin
      grant_valid = req0 | req1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      // Port 1 wins only when port 0 is silent.
      grant_idx = ~req0;
`else
      // A lone requester wins outright. On a tie the pointer decides.
      if (req0 & req1) begin
         grant_idx = prio_q;
      end else begin
         grant_idx = req1;
      end
`endif
   end

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      gidx_d   = gidx_q;
      rbuf_d   = rbuf_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      prio_d   = prio_q;
`endif
      mem_w_en = 1'b0;
      mem_r_en = 1'b0;
      ack0     = 1'b0;
      ack1     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Requests are sampled only here. Anything that arrives later
            // waits for the next IDLE cycle.
            if (grant_valid) begin
               gidx_d  = grant_idx;
               addr_d  = grant_idx ? addr1  : addr0;
               wdata_d = grant_idx ? wdata1 : wdata0;
               we_d    = grant_idx ? we1    : we0;
               state_d = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            mem_w_en = we_q;
            mem_r_en = ~we_q;
            state_d  = ST_BUSY;
         end

         ST_BUSY: begin
            // The controller assembles the 32-bit word while busy. The last
            // sample taken before ready rises is the finished word, so keep
            // overwriting rbuf until then.
            if (!mem_ready) begin
               rbuf_d = mem_rdata;
            end else begin
               // Transfer into the winner's result register now so the word
               // is valid in the same cycle as the ack.
               if (gidx_q) begin
                  rdata1_d = rbuf_q;
               end else begin
                  rdata0_d = rbuf_q;
               end
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            ack0 = ~gidx_q;
            ack1 = gidx_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            prio_d = ~gidx_q;
`endif
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         we_q     <= 1'b0;
         gidx_q   <= 1'b0;
         rbuf_q   <= 32'd0;
         rdata0_q <= 32'd0;
         rdata1_q <= 32'd0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
         prio_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         gidx_q   <= gidx_d;
         rbuf_q   <= rbuf_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
         prio_q   <= prio_d;
`endif
      end
   end

   // -------------------------------------------------------------------------
   // Output wiring
   // -------------------------------------------------------------------------
   // The operands only change on a grant in IDLE, so they are stable from
   // ISSUE through DONE.
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;

   // Zero-latency freeze: a requester stalls until the cycle of its own ack.
   assign stall0 = req0 & ~ack0;
   assign stall1 = req1 & ~ack1;

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = 32'd0, wdata0 = 32'd0, addr1 = 32'd0, wdata1 = 32'd0;
   logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
   logic        ack0, ack1, stall0, stall1, mem_w_en, mem_r_en;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   always #5 clk = ~clk;

   sram_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .rdata0(rdata0), .ack0(ack0), .stall0(stall0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .rdata1(rdata1), .ack1(ack1), .stall1(stall1),
      .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   // ---------------- SRAM controller model (16-bit SRAM) ----------------
   logic [15:0] sram [0:1023];
   logic [2:0]  ctl_phase;
   logic        ctl_we;
   logic [9:0]  ctl_addr;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ctl_phase <= 3'd0;
         ctl_we    <= 1'b0;
         ctl_addr  <= 10'd0;
         mem_ready <= 1'b1;
         mem_rdata <= 32'd0;
      end else if (ctl_phase == 3'd0) begin
         if (mem_w_en || mem_r_en) begin
            ctl_phase <= 3'd1;
            mem_ready <= 1'b0;
            ctl_we    <= mem_w_en;
            ctl_addr  <= mem_addr[9:0];
            mem_rdata <= 32'h5A5A_0000;   // partial word while busy
            if (mem_w_en) begin
               sram[mem_addr[9:0]]         <= mem_wdata[15:0];
               sram[mem_addr[9:0] + 10'd1] <= mem_wdata[31:16];
            end
         end
      end else begin
         if (ctl_phase == 3'd3 && !ctl_we)
            mem_rdata <= {sram[ctl_addr + 10'd1], sram[ctl_addr]};
         if (ctl_phase == 3'd4) begin
            ctl_phase <= 3'd0;
            mem_ready <= 1'b1;
         end else begin
            ctl_phase <= ctl_phase + 3'd1;
         end
      end
   end

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      int          port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          cyc;
   } txn_t;

   txn_t sb[$];
   int   cyc = 0;
   int   done_cnt = 0, wen_cnt = 0, ren_cnt = 0;
   logic [31:0] last_rd0 = 32'd0, last_rd1 = 32'd0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      txn_t t;
      check_value("stall0", 32'(stall0), 32'(req0 & ~ack0));
      check_value("stall1", 32'(stall1), 32'(req1 & ~ack1));
      if (rst) begin
         check_value("rst_ack", 32'({ack1, ack0}), 32'd0);
         check_value("rst_en", 32'({mem_w_en, mem_r_en}), 32'd0);
         last_rd0 = 32'd0;
         last_rd1 = 32'd0;
      end else begin
         if (mem_w_en || mem_r_en) begin
            if (sb.size() == 0) begin
               check_value("unexpected_issue", 32'd1, 32'd0);
            end else begin
               t = sb[0];
               check_value("issue_w_en", 32'(mem_w_en), 32'(t.we));
               check_value("issue_r_en", 32'(mem_r_en), 32'(!t.we));
               check_value("issue_addr", mem_addr, t.addr);
               if (t.we) check_value("issue_wdata", mem_wdata, t.wdata);
            end
            wen_cnt += int'(mem_w_en);
            ren_cnt += int'(mem_r_en);
         end
         if (ack0 || ack1) begin
            check_value("ack_onehot", 32'(ack0 & ack1), 32'd0);
            if (sb.size() == 0) begin
               check_value("unexpected_ack", 32'({ack1, ack0}), 32'd0);
            end else begin
               t = sb.pop_front();
               check_value("ack_port", 32'(ack1), 32'(t.port));
               check_value("ack_cycle", 32'(cyc), 32'(t.cyc));
               check_value("hold_addr", mem_addr, t.addr);
               if (t.we) check_value("hold_wdata", mem_wdata, t.wdata);
               if (t.port == 0) begin
                  if (!t.we) check_value("rdata0", rdata0, t.rdata);
                  check_value("rdata1_hold", rdata1, last_rd1);
               end else begin
                  if (!t.we) check_value("rdata1", rdata1, t.rdata);
                  check_value("rdata0_hold", rdata0, last_rd0);
               end
               $display("txn port%0d %s addr=%h wdata=%h rdata0=%h rdata1=%h cyc=%0d",
                        t.port, t.we ? "WR" : "RD", t.addr, t.wdata, rdata0, rdata1, cyc);
            end
            last_rd0 = rdata0;
            last_rd1 = rdata1;
            done_cnt++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check_value("ack_count", 32'(done_cnt), 32'(target));
   endtask

   task automatic drive_port(input int port, input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] d);
      if (port == 0) begin
         req0 = r; we0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = r; we1 = w; addr1 = a; wdata1 = d;
      end
   endtask

   // One transaction from an idle arbiter. Grant edge is the next posedge.
   task automatic run_txn(input int port, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input bit withdraw);
      txn_t t;
      int   tgt;
      @(posedge clk); #1;
      drive_port(port, 1'b1, w, a, d);
      t = '{port: port, we: w, addr: a, wdata: d, rdata: exp_rd, cyc: cyc + 7};
      sb.push_back(t);
      tgt = done_cnt + 1;
      if (withdraw) begin
         repeat (2) @(posedge clk);
         #1;
         drive_port(port, 1'b0, w, a, d);
      end
      wait_done(tgt, 20);
      drive_port(port, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wen0, ren0, done0, base, tgt;
      txn_t t;

      // Reset state; stall follows req even in reset.
      rst  = 1'b1;
      req0 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_value("rst_ack0", 32'(ack0), 32'd0);
      check_value("rst_ack1", 32'(ack1), 32'd0);
      check_value("rst_w_en", 32'(mem_w_en), 32'd0);
      check_value("rst_r_en", 32'(mem_r_en), 32'd0);
      check_value("rst_mem_addr", mem_addr, 32'd0);
      check_value("rst_mem_wdata", mem_wdata, 32'd0);
      check_value("rst_rdata0", rdata0, 32'd0);
      check_value("rst_rdata1", rdata1, 32'd0);
      check_value("rst_stall0", 32'(stall0), 32'd1);
      check_value("rst_stall1", 32'(stall1), 32'd0);
      req0 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Port 0 write.
      wen0 = wen_cnt;
      run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
      check_value("w_en_pulses", 32'(wen_cnt - wen0), 32'd1);
      check_value("sram_0x10", 32'(sram[10'h10]), 32'h0000BEEF);
      check_value("sram_0x11", 32'(sram[10'h11]), 32'h0000DEAD);

      // Port 1 read back, then port 0 read back.
      run_txn(1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
      run_txn(0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

      // Request withdrawn after grant still completes.
      run_txn(0, 1'b1, 32'h30, 32'hCAFEF00D, 32'd0, 1'b1);
      run_txn(1, 1'b0, 32'h30, 32'd0, 32'hCAFEF00D, 1'b0);

      // Reset during BUSY: no ack, no further enables.
      @(posedge clk); #1;
      drive_port(1, 1'b1, 1'b0, 32'h10, 32'd0);
      t = '{port: 1, we: 1'b0, addr: 32'h10, wdata: 32'd0, rdata: 32'hDEADBEEF, cyc: cyc + 7};
      sb.push_back(t);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      drive_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
      sb.delete();
      done0 = done_cnt;
      wen0  = wen_cnt;
      ren0  = ren_cnt;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_value("rst_no_ack", 32'(done_cnt), 32'(done0));
      check_value("rst_no_w_en", 32'(wen_cnt), 32'(wen0));
      check_value("rst_no_r_en", 32'(ren_cnt), 32'(ren0));
      check_value("rst_mid_rdata1", rdata1, 32'd0);
      run_txn(1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

      // Both ports requesting writes, held high from reset.
      rst = 1'b1;
      drive_port(0, 1'b1, 1'b1, 32'h20, 32'h11112222);
      drive_port(1, 1'b1, 1'b1, 32'h40, 32'h33334444);
      @(posedge clk); #1;
      rst  = 1'b0;
      base = cyc;
      for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
         t = '{port: 0, we: 1'b1, addr: 32'h20, wdata: 32'h11112222, rdata: 32'd0, cyc: base + 7 + 8 * k};
`else
         if ((k % 2) == 0)
            t = '{port: 0, we: 1'b1, addr: 32'h20, wdata: 32'h11112222, rdata: 32'd0, cyc: base + 7 + 8 * k};
         else
            t = '{port: 1, we: 1'b1, addr: 32'h40, wdata: 32'h33334444, rdata: 32'd0, cyc: base + 7 + 8 * k};
`endif
         sb.push_back(t);
      end
      tgt = done_cnt + 4;
      wait_done(tgt, 60);
`ifdef SRAM_ARB_FIXED_PRIO_EN
      // Port 1 starved so far; it wins once req0 drops.
      drive_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
      t = '{port: 1, we: 1'b1, addr: 32'h40, wdata: 32'h33334444, rdata: 32'd0, cyc: base + 39};
      sb.push_back(t);
      wait_done(tgt + 1, 20);
`endif
      drive_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive_port(1, 1'b0, 1'b0, 32'd0, 32'd0);

      // Read back both round-robin writes from the opposite ports.
      run_txn(1, 1'b0, 32'h20, 32'd0, 32'h11112222, 1'b0);
      run_txn(0, 1'b0, 32'h40, 32'd0, 32'h33334444, 1'b0);

      repeat (4) @(posedge clk);
      #1;
      check_value("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single 16-bit external SRAM controller between two 32-bit requesters: port 0 is the pipeline MEM stage and port 1 is a secondary master such as a loader or debug port. The arbiter grants one port at a time and latches its address, write data and direction. It drives the controller's one-cycle read/write enables and holds the operands stable for the whole transaction. It captures the 32-bit read result and returns a one-cycle acknowledge to the winning port. It sits between the requesters and the SRAM controller; all SRAM sequencing remains in the controller.

## Interface
- No parameters. Widths are fixed: 32-bit address, 32-bit data.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0, req1  in  1  access request from port 0 / port 1.
- we0, we1  in  1  1 = write, 0 = read.
- addr0, addr1  in  32  word address; the controller uses bits [17:0].
- wdata0, wdata1  in  32  store data; ignored for reads.
- rdata0, rdata1  out  32  registered read result, valid while the matching ack is high.
- ack0, ack1  out  1  one-cycle completion pulse.
- stall0, stall1  out  1  combinational: reqN & ~ackN; feeds the pipeline freeze.
- mem_w_en, mem_r_en  out  1  enables to the SRAM controller; one-cycle pulse.
- mem_addr, mem_wdata  out  32  latched operands, held constant from ISSUE through DONE.
- mem_rdata  in  32  controller read data.
- mem_ready  in  1  controller ready; low while a transaction is in progress.

## Operation
- States: IDLE, ISSUE, BUSY, DONE. Reset state is IDLE.
- IDLE
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant that port.
  - If both are pending, grant the port selected by the priority pointer.
  - On grant: latch addr, wdata, we and the grant index (gidx), then go to ISSUE.
- ISSUE
  - Assert mem_w_en when latched we = 1; otherwise assert mem_r_en.
  - Always exactly one cycle; next state is BUSY.
- BUSY
  - On every cycle with mem_ready = 0, register mem_rdata into rbuf. The last value captured before ready rises is the valid word.
  - Go to DONE on the first cycle with mem_ready = 1.
- DONE
  - Pulse ack[gidx] for one cycle; rdata[gidx] = rbuf.
  - Round-robin: the pointer moves to prefer the non-granted port.
  - Next state is IDLE.
- Reset values
  - All outputs are 0: acks, enables, mem_addr, mem_wdata, rdata0/1.
  - The stall outputs follow reqN.
  - The priority pointer prefers port 0.
- Boundary conditions
  - A request deasserted after grant still completes; ack still pulses.
  - A request arriving during ISSUE, BUSY or DONE waits for IDLE.
  - The ungranted port's rdata retains its last value; its ack stays 0.
  - rst mid-transaction returns the arbiter to IDLE immediately and discards the transaction with no ack. The controller shares rst and resets with it.
  - mem_addr and mem_wdata must not change between ISSUE and DONE inclusive.

## Timing
- Grant edge E0: IDLE with a pending request.
- The enable is high in the cycle after E0.
- The controller passes through 5 states after E1; mem_ready returns high after E5.
- The arbiter enters DONE at E6; ack is high between E6 and E7.
- Reads and writes both take this path.
- A new grant is sampled at E8 at the earliest, giving one transaction per 8 cycles.
- The stall outputs are combinational and have zero latency.

## Configuration
- Macro: SRAM_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority; port 0 always wins simultaneous requests.
  - The priority pointer logic is removed.
- Undefined (default): round-robin as described above.

## Test plan
- Port 0 write: req0 = 1, we0 = 1, addr0 = 0x10, wdata0 = 0xDEADBEEF.
  - mem_w_en pulses once.
  - ack0 pulses between E6 and E7.
  - SRAM words 0x10 = 0xBEEF and 0x11 = 0xDEAD.
- Port 1 read of address 0x10 after the write above: rdata1 = 0xDEADBEEF while ack1 = 1; ack0 stays 0.
- Round-robin: req0 and req1 held high from reset, both writes.
  - Grant order is 0, 1, 0, 1.
  - Acks are spaced 8 cycles apart.
  - stall is high for each port until its ack.
- Reset during BUSY (rst at E3):
  - State returns to IDLE; no ack is issued; mem enables stay 0.
  - A fresh read afterwards completes normally.
- Request withdrawn: req0 drops one cycle after the grant; ack0 still pulses at E6.
- With SRAM_ARB_FIXED_PRIO_EN defined, both requests held high: port 0 is granted every time and port 1 starves until req0 drops.
